// File: rtl/pattern_match_ctrl_if.sv
// rtl/pattern_match_ctrl_if.sv - config, control, serial input and status bundle for pattern_match_ctrl
interface pattern_match_ctrl_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int TO_W  = 8
);
    logic             cfg_we;
    logic [PAT_W-1:0] cfg_pattern;
    logic [CNT_W-1:0] cfg_target;
    logic [TO_W-1:0]  cfg_timeout;
    logic             start;
    logic             abort;
    logic             x;
    logic             busy;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             done;
    logic             timeout_flag;

    modport master (
        output cfg_we, cfg_pattern, cfg_target, cfg_timeout, start, abort, x,
        input  busy, match, match_count, done, timeout_flag
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_target, cfg_timeout, start, abort, x,
        output busy, match, match_count, done, timeout_flag
    );
endinterface

// File: rtl/pattern_match_ctrl.sv
// rtl/pattern_match_ctrl.sv - serial bit-pattern detector run controller with target/timeout/abort
module pattern_match_ctrl #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int TO_W  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    pattern_match_ctrl_if.slave  bus
);
    localparam int FILL_W = $clog2(PAT_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } state_t;

    state_t           state, state_next;

    logic [PAT_W-1:0] pat_q;
    logic [CNT_W-1:0] tgt_q;
    logic [TO_W-1:0]  to_q;

    logic [PAT_W-1:0] hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [TO_W-1:0]  tmr_q, tmr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             match_q, match_d;
    logic             busy_q, done_q, tflag_q;

    logic [PAT_W-1:0] cand;
    logic             cand_hit;
    logic [CNT_W-1:0] cnt_inc;

    // Candidate window includes the bit arriving on this edge; hits are only
    // trusted once the window holds PAT_W bits from the current run.
    assign cand     = {hist_q[PAT_W-2:0], bus.x};
    assign cand_hit = (fill_q >= FILL_W'(PAT_W - 1)) && (cand == pat_q);
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath next values; abort outranks match, match outranks timeout
    always_comb begin
        state_next = state;
        hist_d     = hist_q;
        fill_d     = fill_q;
        tmr_d      = tmr_q;
        cnt_d      = cnt_q;
        match_d    = 1'b0;
        case (state)
            S_RUN: begin
                if (bus.abort) begin
                    state_next = S_IDLE;
                end else begin
                    hist_d = cand;
                    fill_d = (fill_q >= FILL_W'(PAT_W)) ? fill_q : fill_q + 1'b1;
                    if (cand_hit) begin
                        match_d = 1'b1;
                        cnt_d   = cnt_inc;
                        tmr_d   = '0;
                        if ((tgt_q != '0) && (cnt_inc == tgt_q)) begin
                            state_next = S_DONE;
                        end
                    end else begin
                        tmr_d = (&tmr_q) ? tmr_q : tmr_q + 1'b1;
                        if ((to_q != '0) && (tmr_q == to_q - 1'b1)) begin
                            state_next = S_TIMEOUT;
                        end
                    end
                end
            end
            default: begin
                if (bus.start) begin
                    state_next = S_RUN;
                    hist_d     = '0;
                    fill_d     = '0;
                    tmr_d      = '0;
                    cnt_d      = '0;
                end
            end
        endcase
    end

    // Config latch, only while not running
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pat_q <= '0;
            tgt_q <= CNT_W'(1);
            to_q  <= '0;
        end else if (bus.cfg_we && !busy_q) begin
            pat_q <= bus.cfg_pattern;
            tgt_q <= bus.cfg_target;
            to_q  <= bus.cfg_timeout;
        end
    end

    // Datapath registers: history, fill counter, inactivity timer, match counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
            fill_q <= '0;
            tmr_q  <= '0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            tmr_q  <= tmr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Registered status outputs, decoded from the upcoming state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            match_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tflag_q <= 1'b0;
        end else begin
            match_q <= match_d;
            busy_q  <= (state_next == S_RUN);
            done_q  <= (state_next == S_DONE);
            tflag_q <= (state_next == S_TIMEOUT);
        end
    end

    assign bus.busy         = busy_q;
    assign bus.match        = match_q;
    assign bus.match_count  = cnt_q;
    assign bus.done         = done_q;
    assign bus.timeout_flag = tflag_q;
endmodule

// File: tb/tb_pattern_match_ctrl.sv
// tb/tb_pattern_match_ctrl.sv - directed self-checking bench for pattern_match_ctrl
module tb_pattern_match_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    pattern_match_ctrl_if #(.PAT_W(4), .CNT_W(8), .TO_W(8)) bus ();
    pattern_match_ctrl_if #(.PAT_W(2), .CNT_W(2), .TO_W(8)) bus2 ();

    pattern_match_ctrl #(.PAT_W(4), .CNT_W(8), .TO_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    pattern_match_ctrl #(.PAT_W(2), .CNT_W(2), .TO_W(8)) dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic step(input logic xv);
        bus.x = xv;
        tick();
    endtask

    task automatic step2(input logic xv);
        bus2.x = xv;
        tick();
    endtask

    task automatic cfg_write(input logic [3:0] p, input logic [7:0] t, input logic [7:0] to);
        bus.cfg_we      = 1'b1;
        bus.cfg_pattern = p;
        bus.cfg_target  = t;
        bus.cfg_timeout = to;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  32'(bus.busy), 0);
        check({tag, "_match"}, 32'(bus.match), 0);
        check({tag, "_count"}, 32'(bus.match_count), 0);
        check({tag, "_done"},  32'(bus.done), 0);
        check({tag, "_tflag"}, 32'(bus.timeout_flag), 0);
    endtask

    logic [6:0] det_x;
    logic [6:0] det_m;
    logic [5:0] sat_m;
    logic [1:0] sat_c [6];

    initial begin
        bus.cfg_we = 0; bus.cfg_pattern = 0; bus.cfg_target = 0; bus.cfg_timeout = 0;
        bus.start = 0; bus.abort = 0; bus.x = 0;
        bus2.cfg_we = 0; bus2.cfg_pattern = 0; bus2.cfg_target = 0; bus2.cfg_timeout = 0;
        bus2.start = 0; bus2.abort = 0; bus2.x = 0;

        repeat (3) tick();
        check_idle_outputs("rst_hold");
        reset = 1'b1;
        tick();

        // defaults: pattern 0000, target 1, timeout disabled
        do_start();
        check("def_busy", 32'(bus.busy), 1);
        step(0); step(0); step(0);
        check("def_fill_nomatch", 32'(bus.match), 0);
        step(0);
        check("def_match", 32'(bus.match), 1);
        check("def_count", 32'(bus.match_count), 1);
        check("def_done", 32'(bus.done), 1);
        check("def_busy_drop", 32'(bus.busy), 0);
        step(0);
        check("def_done_hold", 32'(bus.done), 1);
        check("def_done_nomatch", 32'(bus.match), 0);

        // reset mid-run, one sample before a pending match
        do_start();
        check("restart_done_clr", 32'(bus.done), 0);
        check("restart_count_clr", 32'(bus.match_count), 0);
        step(0); step(0); step(0);
        reset = 1'b0;
        #2;
        check_idle_outputs("rst_mid");
        tick();
        check("rst_mid_nopulse", 32'(bus.match), 0);
        reset = 1'b1;
        tick();

        // basic detect with overlap, target 2
        cfg_write(4'b1001, 8'd2, 8'd0);
        do_start();
        det_x = 7'b1001001;
        det_m = 7'b0001001;
        for (int i = 0; i < 7; i++) begin
            step(det_x[6-i]);
            check($sformatf("det_match_%0d", i), 32'(bus.match), 32'(det_m[6-i]));
        end
        check("det_count", 32'(bus.match_count), 2);
        check("det_done", 32'(bus.done), 1);
        check("det_busy", 32'(bus.busy), 0);

        // fill guard with all-zero pattern, unlimited target
        cfg_write(4'b0000, 8'd0, 8'd0);
        do_start();
        step(0); check("fill_1", 32'(bus.match), 0);
        step(0); check("fill_2", 32'(bus.match), 0);
        step(0); check("fill_3", 32'(bus.match), 0);
        step(0); check("fill_4", 32'(bus.match), 1);
        check("fill_4_count", 32'(bus.match_count), 1);
        step(0); check("fill_5", 32'(bus.match), 1);
        check("fill_5_count", 32'(bus.match_count), 2);
        check("fill_busy", 32'(bus.busy), 1);
        bus.abort = 1'b1;
        step(0);
        bus.abort = 1'b0;
        check("fill_abort_busy", 32'(bus.busy), 0);
        check("fill_abort_count", 32'(bus.match_count), 2);

        // timeout after 5 non-matching samples
        cfg_write(4'b1001, 8'd0, 8'd5);
        do_start();
        for (int i = 0; i < 4; i++) begin
            step(1);
            check($sformatf("to_pre_%0d", i), 32'(bus.timeout_flag), 0);
        end
        step(1);
        check("to_flag", 32'(bus.timeout_flag), 1);
        check("to_busy", 32'(bus.busy), 0);
        check("to_count", 32'(bus.match_count), 0);

        // a match on the 4th sample clears the timer
        do_start();
        check("to2_flag_clr", 32'(bus.timeout_flag), 0);
        step(1); step(0); step(0);
        step(1);
        check("to2_match", 32'(bus.match), 1);
        for (int i = 0; i < 4; i++) begin
            step(1);
            check($sformatf("to2_hold_%0d", i), 32'(bus.timeout_flag), 0);
        end
        step(1);
        check("to2_flag", 32'(bus.timeout_flag), 1);
        check("to2_count", 32'(bus.match_count), 1);

        // config lockout while running, then abort on a completing bit
        cfg_write(4'b1001, 8'd0, 8'd0);
        do_start();
        step(1); step(0);
        bus.cfg_we = 1'b1; bus.cfg_pattern = 4'b0110; bus.cfg_target = 8'd1;
        step(0);
        bus.cfg_we = 1'b0;
        step(1);
        check("lock_match", 32'(bus.match), 1);
        check("lock_count", 32'(bus.match_count), 1);
        check("lock_busy", 32'(bus.busy), 1);
        step(0); step(0);
        bus.abort = 1'b1;
        step(1);
        check("abort_nomatch", 32'(bus.match), 0);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_count", 32'(bus.match_count), 1);
        step(0);
        bus.abort = 1'b0;
        check("abort_idle_count", 32'(bus.match_count), 1);
        check("abort_idle_busy", 32'(bus.busy), 0);

        // saturation on the narrow instance, unlimited target
        bus2.cfg_we = 1'b1; bus2.cfg_pattern = 2'b11; bus2.cfg_target = 2'd0; bus2.cfg_timeout = 8'd0;
        tick();
        bus2.cfg_we = 1'b0;
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        sat_m = 6'b011111;
        sat_c[0] = 2'd0; sat_c[1] = 2'd1; sat_c[2] = 2'd2;
        sat_c[3] = 2'd3; sat_c[4] = 2'd3; sat_c[5] = 2'd3;
        for (int i = 0; i < 6; i++) begin
            step2(1);
            check($sformatf("sat_match_%0d", i), 32'(bus2.match), 32'(sat_m[5-i]));
            check($sformatf("sat_count_%0d", i), 32'(bus2.match_count), 32'(sat_c[i]));
        end
        check("sat_busy", 32'(bus2.busy), 1);
        check("sat_done", 32'(bus2.done), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
